// File: rtl/tts_pkg.sv
// Shared types and width helpers for the truth-table sweeper.
package tts_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } tts_state_e;

  // Default geometry and the widths derived from it.
  localparam int N_IN_DEF = 3;
  localparam int N_FN_DEF = 5;
  localparam int VEC_W    = N_IN_DEF;
  localparam int CNT_W    = N_IN_DEF + 1;
  localparam int FN_W     = (N_FN_DEF > 1) ? $clog2(N_FN_DEF) : 1;

  // Index width for n_fn functions; a single function still needs one bit.
  function automatic int fn_width(input int n_fn);
    return (n_fn > 1) ? $clog2(n_fn) : 1;
  endfunction

endpackage

// File: rtl/tt_lut_slice.sv
// One function channel: LUT storage, gated lookup and minterm counter.
module tt_lut_slice #(
  parameter int N_IN = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [(1<<N_IN)-1:0]   wdata,
  input  logic [N_IN-1:0]        vec,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   acc,
  output logic                   s,
  output logic [N_IN:0]          cnt
);

  logic [(1<<N_IN)-1:0] lut;

  // LUT register; the top only raises we while idle, so it is frozen mid-sweep.
  always_ff @(posedge clk) begin
    if (reset)   lut <= '0;
    else if (we) lut <= wdata;
  end

  // Lookup is forced low outside a beat so idle outputs stay quiet.
  assign s = en & lut[vec];

  // Minterm counter: cleared on sweep start, bumped on each accepted beat.
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (acc)  cnt <= cnt + {{N_IN{1'b0}}, s};
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Programmable multi-function truth-table engine: sweeps every input vector,
// streams the vector with all function outputs, then reports minterm counts.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int  N_IN = N_IN_DEF,
  parameter int  N_FN = N_FN_DEF,
  localparam int FW   = fn_width(N_FN),
  localparam int LW   = 1 << N_IN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [FW-1:0]            cfg_fn,
  input  logic [LW-1:0]            cfg_lut,
  output logic                     cfg_err,
  input  logic                     start,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_IN-1:0]          out_vec,
  output logic [N_FN-1:0]          out_s,
  output logic                     done,
  output logic [N_FN*(N_IN+1)-1:0] ones_cnt
);

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  tts_state_e                 state;
  logic                       fn_ok;
  logic                       xfer;
  logic                       sweep_go;
  logic [N_FN-1:0][N_IN:0]    cnt_a;

  assign fn_ok    = (int'(cfg_fn) < N_FN);
  assign xfer     = out_valid & out_ready;
  assign sweep_go = (state == ST_IDLE) & start;
  assign ones_cnt = cnt_a;

  // One slice per function; only the addressed slice is written, and only while idle.
  for (genvar f = 0; f < N_FN; f++) begin : g_fn
    tt_lut_slice #(.N_IN(N_IN)) u_slice (
      .clk   (clk),
      .reset (reset),
      .we    (cfg_we && (state == ST_IDLE) && (int'(cfg_fn) == f)),
      .wdata (cfg_lut),
      .vec   (out_vec),
      .en    (out_valid),
      .clr   (sweep_go),
      .acc   (xfer),
      .s     (out_s[f]),
      .cnt   (cnt_a[f])
    );
  end

  // Sweep FSM: vector counter doubles as out_vec, all status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && ((state != ST_IDLE) || !fn_ok);
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SWEEP;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_vec   <= '0;
          end
        end
        ST_SWEEP: begin
          if (xfer) begin
            if (out_vec == VEC_LAST) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              out_vec   <= '0;
              done      <= 1'b1;
            end else begin
              out_vec <= out_vec + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
